// File: rtl/wb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// wb_rr_arbiter
// Two-master / one-slave Wishbone classic arbiter with round-robin grant.
// A grant is held for the whole cyc assertion of the winning master, so
// bursts and read-modify-write sequences reach the slave atomically.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   m0_* / m1_*                 master side (adr, dat_w, sel, we, cyc, stb in;
//                               dat_r, ack, err out)
//   s_*                         slave side (adr, dat_w, sel, we, cyc, stb out;
//                               dat_r, ack, err in)
//
// Optional build macro:
//   WB_ARB_TIMEOUT_EN  adds a slave-ack watchdog; after TIMEOUT unacknowledged
//                      strobe cycles the granted master receives a one-cycle
//                      err and the slave strobe/cyc are dropped for that cycle.
// ---------------------------------------------------------------------------
module wb_rr_arbiter #(
    parameter int ADDR_WIDTH = 20,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] m0_adr,
    input  logic [31:0]           m0_dat_w,
    input  logic [3:0]            m0_sel,
    input  logic                  m0_we,
    input  logic                  m0_cyc,
    input  logic                  m0_stb,
    output logic [31:0]           m0_dat_r,
    output logic                  m0_ack,
    output logic                  m0_err,
    input  logic [ADDR_WIDTH-1:0] m1_adr,
    input  logic [31:0]           m1_dat_w,
    input  logic [3:0]            m1_sel,
    input  logic                  m1_we,
    input  logic                  m1_cyc,
    input  logic                  m1_stb,
    output logic [31:0]           m1_dat_r,
    output logic                  m1_ack,
    output logic                  m1_err,
    output logic [ADDR_WIDTH-1:0] s_adr,
    output logic [31:0]           s_dat_w,
    output logic [3:0]            s_sel,
    output logic                  s_we,
    output logic                  s_cyc,
    output logic                  s_stb,
    input  logic [31:0]           s_dat_r,
    input  logic                  s_ack,
    input  logic                  s_err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] GNT0 = 2'd1;
    localparam logic [1:0] GNT1 = 2'd2;

    logic [1:0] state_reg, state_next;
    logic       last_reg, last_next;

    // Arbitration: a lone requester wins; on a tie the master that did not
    // win last time is chosen. Release happens only when the owner drops cyc.
    always_comb begin
        state_next = state_reg;
        last_next  = last_reg;
        case (state_reg)
            IDLE: begin
                if (m0_cyc && (!m1_cyc || last_reg)) begin
                    state_next = GNT0;
                    last_next  = 1'b0;
                end else if (m1_cyc) begin
                    state_next = GNT1;
                    last_next  = 1'b1;
                end
            end
            GNT0:    if (!m0_cyc) state_next = IDLE;
            GNT1:    if (!m1_cyc) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            last_reg  <= 1'b1;
        end else begin
            state_reg <= state_next;
            last_reg  <= last_next;
        end
    end

    // Grants are masked by rst so every output is quiet for the whole time
    // reset is asserted, not only after the reset edge has been taken.
    logic [1:0] gnt;
    assign gnt[0] = (state_reg == GNT0) && !rst;
    assign gnt[1] = (state_reg == GNT1) && !rst;

    logic cyc_raw, stb_raw, timeout_hit;
    assign cyc_raw = (gnt[0] && m0_cyc) || (gnt[1] && m1_cyc);
    assign stb_raw = (gnt[0] && m0_cyc && m0_stb) || (gnt[1] && m1_cyc && m1_stb);

    assign s_adr   = gnt[0] ? m0_adr   : gnt[1] ? m1_adr   : '0;
    assign s_dat_w = gnt[0] ? m0_dat_w : gnt[1] ? m1_dat_w : '0;
    assign s_sel   = gnt[0] ? m0_sel   : gnt[1] ? m1_sel   : '0;
    assign s_we    = gnt[0] ? m0_we    : gnt[1] ? m1_we    : 1'b0;
    assign s_cyc   = cyc_raw && !timeout_hit;
    assign s_stb   = stb_raw && !timeout_hit;

`ifdef WB_ARB_TIMEOUT_EN
    localparam int         CW     = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);

    logic [CW-1:0] cnt_reg, cnt_next;

    // Hit is qualified with the raw cycle so a master that has already let
    // go is never handed a spurious error.
    assign timeout_hit = cyc_raw && (cnt_reg == TO_VAL);

    always_comb begin
        cnt_next = cnt_reg + 1'b1;
        if (timeout_hit || s_ack || s_err || !s_stb || (state_next != state_reg))
            cnt_next = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_reg <= '0;
        else     cnt_reg <= cnt_next;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Per-master return path. Ack/err are gated by s_cyc so a slave response
    // arriving in the same cycle as an abort is swallowed.
    logic [31:0] m_dat_r [2];
    logic [1:0]  m_ack, m_err;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ret
            assign m_ack[gi]   = gnt[gi] && s_ack && s_cyc;
            assign m_err[gi]   = gnt[gi] && ((s_err && s_cyc) || timeout_hit);
            assign m_dat_r[gi] = gnt[gi] ? s_dat_r : 32'd0;
        end
    endgenerate

    assign m0_ack   = m_ack[0];
    assign m1_ack   = m_ack[1];
    assign m0_err   = m_err[0];
    assign m1_err   = m_err[1];
    assign m0_dat_r = m_dat_r[0];
    assign m1_dat_r = m_dat_r[1];

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_rr_arbiter
// Directed bench for wb_rr_arbiter. Inputs change 1 time unit after each
// rising edge and outputs are sampled 1 unit later, well away from the edge.
// ---------------------------------------------------------------------------
module tb_wb_rr_arbiter;

    localparam int AW = 20;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] m0_adr, m1_adr, s_adr;
    logic [31:0]   m0_dat_w, m1_dat_w, m0_dat_r, m1_dat_r, s_dat_w, s_dat_r;
    logic [3:0]    m0_sel, m1_sel, s_sel;
    logic          m0_we, m1_we, m0_cyc, m1_cyc, m0_stb, m1_stb;
    logic          m0_ack, m1_ack, m0_err, m1_err;
    logic          s_we, s_cyc, s_stb, s_ack, s_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    wb_rr_arbiter #(.ADDR_WIDTH(AW), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .m0_adr(m0_adr), .m0_dat_w(m0_dat_w), .m0_sel(m0_sel), .m0_we(m0_we),
        .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_dat_r(m0_dat_r), .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_adr(m1_adr), .m1_dat_w(m1_dat_w), .m1_sel(m1_sel), .m1_we(m1_we),
        .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_dat_r(m1_dat_r), .m1_ack(m1_ack), .m1_err(m1_err),
        .s_adr(s_adr), .s_dat_w(s_dat_w), .s_sel(s_sel), .s_we(s_we),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_dat_r(s_dat_r), .s_ack(s_ack), .s_err(s_err)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after an input change.
    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1;
        m0_adr = '0; m0_dat_w = '0; m0_sel = '0; m0_we = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
        m1_adr = '0; m1_dat_w = '0; m1_sel = '0; m1_we = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
        s_dat_r = '0; s_ack = 1'b0; s_err = 1'b0;

        // ---- 1: reset with both masters requesting and a stray slave ack
        m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
        m0_adr = 20'h00AA0; m1_adr = 20'h00BB0; s_ack = 1'b1; s_err = 1'b1;
        settle();
        check_val("rst_s_cyc_pre", s_cyc, 0);
        check_val("rst_acks_pre", {m0_ack, m1_ack, m0_err, m1_err}, 0);
        tick();
        check_val("rst_s_cyc_edge", s_cyc, 0);
        check_val("rst_s_adr_edge", s_adr, 0);
        check_val("rst_acks_edge", {m0_ack, m1_ack, m0_err, m1_err}, 0);
        rst = 1'b0; s_ack = 1'b0; s_err = 1'b0;
        settle();
        check_val("post_rst_idle", s_cyc, 0);
        tick();
        check_val("first_gnt_m0_cyc", s_cyc, 1);
        check_val("first_gnt_m0_adr", s_adr, 20'h00AA0);
        m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
        settle();
        check_val("first_gnt_release", s_cyc, 0);
        tick();                                   // IDLE, last = m0

        // ---- 2: m0 single write, slave acks one cycle after strobe
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b1; m0_adr = 20'h00010;
        m0_dat_w = 32'hDEADBEEF; m0_sel = 4'hF;
        settle();
        check_val("wr_req_cycle", s_cyc, 0);
        tick();
        check_val("wr_s_cyc", s_cyc, 1);
        check_val("wr_s_adr", s_adr, 20'h00010);
        check_val("wr_s_dat_w", s_dat_w, 32'hDEADBEEF);
        check_val("wr_s_sel_we", {s_sel, s_we}, 5'h1F);
        check_val("wr_no_ack_yet", m0_ack, 0);
        tick();
        s_ack = 1'b1;
        settle();
        check_val("wr_acks", {m0_ack, m1_ack}, 2'b10);
        tick();
        s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0;
        settle();
        check_val("wr_ack_pulse_end", m0_ack, 0);
        check_val("wr_drop_s_cyc", s_cyc, 0);
        tick();                                   // IDLE

        // ---- mid-operation reset while m1 holds the bus
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 20'h00200;
        tick();
        s_dat_r = 32'h12345678;
        settle();
        check_val("m1_gnt_adr", s_adr, 20'h00200);
        check_val("m1_dat_r", m1_dat_r, 32'h12345678);
        check_val("m0_dat_r_masked", m0_dat_r, 0);
        rst = 1'b1;
        settle();
        check_val("midrst_s_cyc", s_cyc, 0);
        check_val("midrst_dat_r", m1_dat_r, 0);
        tick();
        rst = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
        settle();
        check_val("midrst_after_edge", s_cyc, 0);

        // ---- 3: simultaneous requests alternate m0, bubble, m1, then m0
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 20'h00020;
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 20'h00030;
        tick();
        s_ack = 1'b1; s_dat_r = 32'hA0A0A0A0;
        settle();
        check_val("tie1_adr_m0", s_adr, 20'h00020);
        check_val("tie1_acks", {m0_ack, m1_ack}, 2'b10);
        check_val("tie1_m1_dat_r", m1_dat_r, 0);
        tick();
        s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
        settle();
        check_val("tie1_m0_drop", s_cyc, 0);
        tick();
        check_val("tie1_bubble", s_cyc, 0);
        tick();
        s_ack = 1'b1;
        settle();
        check_val("tie1_adr_m1", s_adr, 20'h00030);
        check_val("tie1_m1_acks", {m0_ack, m1_ack}, 2'b01);
        tick();
        s_ack = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
        tick();                                   // IDLE, last = m1
        m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
        tick();
        check_val("tie2_adr_m0", s_adr, 20'h00020);
        m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
        tick();                                   // IDLE

        // ---- 4: m0 4-beat burst, m1 requests mid-burst
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 20'h00100;
        m1_adr = 20'h00300;
        tick();
        for (int b = 0; b < 4; b++) begin
            m0_adr = 20'h00100 + 20'(4 * b);
            s_ack = 1'b1; s_dat_r = 32'(b + 1);
            if (b == 1) begin
                m1_cyc = 1'b1; m1_stb = 1'b1;
            end
            settle();
            check_val($sformatf("burst%0d_adr", b), s_adr, 20'h00100 + 20'(4 * b));
            check_val($sformatf("burst%0d_m0", b), {m0_ack, m0_dat_r}, {1'b1, 32'(b + 1)});
            check_val($sformatf("burst%0d_m1", b), {m1_ack, m1_dat_r}, 0);
            tick();
        end
        s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
        settle();
        check_val("burst_release", s_cyc, 0);
        tick();
        check_val("burst_bubble", s_cyc, 0);
        tick();
        check_val("burst_m1_gnt", {s_cyc, s_adr}, {1'b1, 20'h00300});

        // ---- 5: m1 aborts in the same cycle the slave acks; m0 pending
        m1_cyc = 1'b0; m1_stb = 1'b0; s_ack = 1'b1;
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 20'h00040;
        settle();
        check_val("abort_s_cyc_stb", {s_cyc, s_stb}, 0);
        check_val("abort_acks", {m0_ack, m1_ack}, 0);
        tick();
        s_ack = 1'b0;
        settle();
        check_val("abort_idle", s_cyc, 0);
        tick();
        check_val("abort_m0_gnt", {s_cyc, s_adr}, {1'b1, 20'h00040});
        m0_cyc = 1'b0; m0_stb = 1'b0;
        tick();                                   // IDLE

        // ---- 6: silent slave
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 20'h00050;
        tick();
        check_val("to_first_stb", s_stb, 1);
`ifdef WB_ARB_TIMEOUT_EN
        for (int k = 1; k <= 9; k++) begin
            tick();
            check_val($sformatf("to_k%0d_err", k), m0_err, (k == 8) ? 1 : 0);
            check_val($sformatf("to_k%0d_stb", k), {s_cyc, s_stb}, (k == 8) ? 0 : 2'b11);
        end
`else
        for (int k = 1; k <= 100; k++) tick();
        check_val("stall_err", {m0_err, m0_ack}, 0);
        check_val("stall_stb", {s_cyc, s_stb}, 2'b11);
`endif
        m0_cyc = 1'b0; m0_stb = 1'b0;
        tick();
        tick();
        check_val("end_idle", s_cyc, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
